// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg : shared state encoding and default width for the countdown timer
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

    localparam int TMR_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler : emits a one-cycle tick every DIV enabled cycles
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic sync_clear,
    output logic tick
);

    localparam int              CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With DIV=1 the count stays at zero, so every enabled cycle ticks.
    assign tick = en && (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (sync_clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_timer_ctrl : programmable down-counter with load/start/stop/pause,
// prescaled tick, terminal-count done pulse and optional auto-reload. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int W   = TMR_W,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] preset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         auto_reload,
    output logic [W-1:0] Q,
    output logic         busy,
    output logic         done
);

    state_e       st_q, st_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] rld_q, rld_d;
    logic         done_q, done_d;
    logic         busy_q;
    logic [W-1:0] eff_q;
    logic         pre_en;
    logic         pre_clr;
    logic         tick;

    // Prescaler only advances in an undisturbed RUN cycle; stop and pause
    // both suppress the tick of the cycle in which they are seen.
    assign pre_en  = (st_q == S_RUN) && !stop && !pause;
    assign pre_clr = (st_q == S_IDLE) && !stop && start;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk        (clk),
        .clr        (clr),
        .en         (pre_en),
        .sync_clear (pre_clr),
        .tick       (tick)
    );

    assign eff_q = load ? preset : q_q;

    always_comb begin
        st_d   = st_q;
        q_d    = q_q;
        rld_d  = rld_q;
        done_d = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (!stop) begin
                    if (load) begin
                        q_d   = preset;
                        rld_d = preset;
                    end
                    if (start) begin
                        if (eff_q != '0) begin
                            st_d = S_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    st_d = S_IDLE;
                end else if (pause) begin
                    st_d = S_PAUSE;
                end else if (tick) begin
                    if (q_q > W'(1)) begin
                        q_d = q_q - W'(1);
                    end else begin
                        done_d = 1'b1;
                        // A zero reload value would re-enter RUN at zero; treat it as a plain stop.
                        if (auto_reload && (rld_q != '0)) begin
                            q_d = rld_q;
                        end else begin
                            q_d  = '0;
                            st_d = S_IDLE;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    st_d = S_IDLE;
                end else if (!pause) begin
                    st_d = S_RUN;
                end
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_q   <= S_IDLE;
            q_q    <= '1;
            rld_q  <= '1;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            q_q    <= q_d;
            rld_q  <= rld_d;
            done_q <= done_d;
            busy_q <= (st_d != S_IDLE);
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire
